mux_8_1_16_rr_sched: RTL and testbench
======================================

// Module: mux_8_1_16_rr_sched
// PURPOSE
//   Round-robin scheduler that shares one 8:1 x 16-bit word mux (mux_8_1_16) among eight requesters.
//   Arbitrates requests, drives the mux selects s2/s1/s0 and registers the selected word.
//   Presents the word on a valid/ready output port and returns a one-cycle ack to the served requester.
//   Sits between the eight source registers and a single downstream consumer.
// PARAMETERS
//   WIDTH   16   data width of each input word and of out
// PORTS
//   clk        in   1      single system clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   req        in   8      req[k]=1: requester k has word ik ready
//   i0..i7     in   WIDTH  requester data words, fed to the shared mux
//   out_ready  in   1      downstream accepts out this cycle
//   s2,s1,s0   out  1 each mux select, {s2,s1,s0} = granted index
//   grant      out  8      one-hot grant, registered
//   out        out  WIDTH  registered selected word
//   out_valid  out  1      out holds a word awaiting acceptance
//   ack        out  8      one-hot, one-cycle pulse: word of requester k delivered
// BEHAVIOUR
//   Clock/reset: one clock (clk); reset is asynchronous and active-high, all state cleared immediately.
//   Reset values: state=IDLE, ptr=7, {s2,s1,s0}=0, grant=0, out=0, out_valid=0, ack=0.
//   ptr = index of last served requester; priority order ptr+1, ptr+2 .. ptr (mod 8, wraps 7->0).
//   Out of reset requester 0 has highest priority.
//   FSM states IDLE -> LOAD -> SEND -> IDLE.
//   IDLE:
//     - eligible = req & ~ack (the requester acked this cycle is masked).
//     - If eligible != 0: pick first eligible in priority order.
//     - Register {s2,s1,s0} and grant; go to LOAD.
//     - Else stay in IDLE; selects hold their last value; grant=0.
//   LOAD:
//     - out <= mux output for current selects (i[sel]); out_valid <= 1; go to SEND.
//     - Data is sampled only on this edge; later changes to i[sel] are ignored.
//   SEND:
//     - Hold out, selects and grant stable while out_valid=1 and out_ready=0 (unbounded stall).
//     - On an edge with out_ready=1: out_valid <= 0, grant <= 0.
//     - Same edge: ack[sel] <= 1 for exactly one cycle, ptr <= sel, go to IDLE.
//   Latency: req seen in IDLE at edge N -> selects at N+1 -> out_valid=1 after N+2.
//   Best-case throughput: one word per 3 cycles.
//   No cancel: dropping req[k] during LOAD/SEND does not abort; the word is still delivered and acked.
//   Requesters hold req until ack; req still high in the ack cycle is masked (no double grant).
//   Simultaneous requests: exactly one grant; each continuously requesting source is served
//   within 8 transfers (starvation-free).
//   out_ready while out_valid=0 is ignored.
//   Reset mid-operation (LOAD/SEND): transfer dropped, no ack, all outputs to reset values.
//   grant, ack and out_valid never have more than one bit / one state active; selects never X after reset.
// TESTING
//   1. Reset, req=8'h01, i0=16'd10, out_ready=1 -> selects 000; out=10, out_valid=1 two edges after req;
//      next edge ack=8'h01 for one cycle.
//   2. req=8'hFF held, out_ready=1, i_k=k+1 -> words 1,2,..,8 then 1 again; ack order 0..7,0.
//   3. req=8'h81 after serving 7 (ptr=7) -> 0 granted first, then 7; wrap-around verified.
//   4. Stall: out_ready=0 for 5 cycles in SEND -> out, selects, grant stable; ack only after out_ready=1.
//   5. Change i2 from 22 to 99 after LOAD, and drop req[2] in SEND -> out stays 22, ack[2] still pulses.
//   6. Assert reset during SEND -> out_valid, grant, ack, out go 0 asynchronously;
//      after release req=8'h04 is served normally.

Source files
------------

// File: rtl/mux_8_1_16_rr_sched.sv
// Round-robin scheduler sharing one 8:1 word mux among eight requesters.
// Grants via IDLE->LOAD->SEND, registers the selected word and acks on hand-off.
module mux_8_1_16_rr_sched #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       req,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    input  logic [WIDTH-1:0] i5,
    input  logic [WIDTH-1:0] i6,
    input  logic [WIDTH-1:0] i7,
    input  logic             out_ready,
    output logic             s2,
    output logic             s1,
    output logic             s0,
    output logic [7:0]       grant,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [7:0]       ack
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       sel_q, sel_d;
    logic [7:0]       grant_q, grant_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       ack_q, ack_d;

    logic [WIDTH-1:0] in_arr [8];
    logic [7:0]       eligible;
    logic [2:0]       pick_idx;
    logic [2:0]       cand;
    logic             found;
    logic [7:0]       pick_onehot;
    logic [7:0]       sel_onehot;

    assign in_arr[0] = i0;
    assign in_arr[1] = i1;
    assign in_arr[2] = i2;
    assign in_arr[3] = i3;
    assign in_arr[4] = i4;
    assign in_arr[5] = i5;
    assign in_arr[6] = i6;
    assign in_arr[7] = i7;

    // The requester being acked this cycle still holds req; mask it to avoid a double grant.
    assign eligible = req & ~ack_q;

    always_comb begin
        found    = 1'b0;
        pick_idx = ptr_q;
        cand     = ptr_q;
        for (int off = 1; off <= 8; off++) begin
            cand = ptr_q + 3'(off);
            if (!found && eligible[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
        assign pick_onehot[gi] = (pick_idx == 3'(gi));
        assign sel_onehot[gi]  = (sel_q == 3'(gi));
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        grant_d     = grant_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        ack_d       = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = pick_idx;
                    grant_d = pick_onehot;
                    state_d = LOAD;
                end else begin
                    grant_d = '0;
                end
            end
            LOAD: begin
                out_d       = in_arr[sel_q];
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    grant_d     = '0;
                    ack_d       = sel_onehot;
                    ptr_d       = sel_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd7;
            sel_q       <= 3'd0;
            grant_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            grant_q     <= grant_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ack_q       <= ack_d;
        end
    end

    assign {s2, s1, s0} = sel_q;
    assign grant        = grant_q;
    assign out          = out_q;
    assign out_valid    = out_valid_q;
    assign ack          = ack_q;

endmodule

// File: tb/tb_mux_8_1_16_rr_sched.sv
// Directed bench for the round-robin word-mux scheduler: latency, rotation,
// wrap-around, stall, data capture / no-cancel and asynchronous reset.
module tb_mux_8_1_16_rr_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  req;
    logic [15:0] tb_i [8];
    logic        out_ready;
    logic        s2, s1, s0;
    logic [7:0]  grant;
    logic [15:0] out;
    logic        out_valid;
    logic [7:0]  ack;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mux_8_1_16_rr_sched #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .req(req),
        .i0(tb_i[0]), .i1(tb_i[1]), .i2(tb_i[2]), .i3(tb_i[3]),
        .i4(tb_i[4]), .i5(tb_i[5]), .i6(tb_i[6]), .i7(tb_i[7]),
        .out_ready(out_ready), .s2(s2), .s1(s1), .s0(s0),
        .grant(grant), .out(out), .out_valid(out_valid), .ack(ack)
    );

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s timeout: out_valid actual %b required 1", name, out_valid);
        end
    endtask

    // One full transfer with out_ready=1: wait for the word, check it, then check the ack pulse.
    task automatic do_transfer(input int idx, input logic [15:0] word, input string name);
        bit         ok;
        logic [7:0] oh;
        oh = 8'd1 << idx;
        wait_valid(name, ok);
        if (ok) begin
            tests_run++;
            if ({s2, s1, s0} !== 3'(idx)) begin
                tests_failed++;
                $display("FAIL %s sel: actual %0d required %0d", name, {s2, s1, s0}, idx);
            end
            tests_run++;
            if (grant !== oh) begin
                tests_failed++;
                $display("FAIL %s grant: actual %h required %h", name, grant, oh);
            end
            tests_run++;
            if (out !== word) begin
                tests_failed++;
                $display("FAIL %s out: actual %0d required %0d", name, out, word);
            end
            @(negedge clk);
            tests_run++;
            if (ack !== oh || out_valid !== 1'b0 || grant !== 8'h00) begin
                tests_failed++;
                $display("FAIL %s ack: actual ack=%h valid=%b grant=%h required ack=%h valid=0 grant=00",
                         name, ack, out_valid, grant, oh);
            end
        end
        $display("[TB] %s: requester %0d word %0d ack %h", name, idx, out, ack);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 8'h00;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) tb_i[k] = 16'(k + 1);
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({s2, s1, s0} !== 3'd0 || grant !== 8'h00 || out !== 16'd0 ||
            out_valid !== 1'b0 || ack !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_values: actual sel=%0d grant=%h out=%0d valid=%b ack=%h required all 0",
                     {s2, s1, s0}, grant, out, out_valid, ack);
        end
        $display("[TB] reset: sel=%0d grant=%h out=%0d valid=%b", {s2, s1, s0}, grant, out, out_valid);
        reset = 1'b0;
    endtask

    task automatic test_single();
        req = 8'h01;
        tb_i[0] = 16'd10;
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (grant !== 8'h01 || {s2, s1, s0} !== 3'd0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_grant: actual grant=%h sel=%0d valid=%b required 01/0/0",
                     grant, {s2, s1, s0}, out_valid);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out !== 16'd10) begin
            tests_failed++;
            $display("FAIL single_out: actual valid=%b out=%0d required 1/10", out_valid, out);
        end
        @(negedge clk);
        tests_run++;
        if (ack !== 8'h01 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_ack: actual ack=%h valid=%b required 01/0", ack, out_valid);
        end
        $display("[TB] single: requester 0 word %0d ack %h", out, ack);
        // req[0] held through the ack cycle must not be re-granted on that edge.
        @(negedge clk);
        tests_run++;
        if (ack !== 8'h00 || grant !== 8'h00) begin
            tests_failed++;
            $display("FAIL mask_ack: actual ack=%h grant=%h required 00/00", ack, grant);
        end
        @(negedge clk);
        tests_run++;
        if (grant !== 8'h01) begin
            tests_failed++;
            $display("FAIL regrant: actual grant=%h required 01", grant);
        end
        do_transfer(0, 16'd10, "single_again");
        req = 8'h00;
    endtask

    task automatic test_rotation();
        apply_reset();
        for (int k = 0; k < 8; k++) tb_i[k] = 16'(k + 1);
        out_ready = 1'b1;
        req = 8'hFF;
        for (int n = 0; n < 9; n++) do_transfer(n % 8, 16'((n % 8) + 1), "rotation");
    endtask

    task automatic test_wrap();
        req = 8'h80;
        do_transfer(7, 16'd8, "wrap_prime");
        req = 8'h81;
        do_transfer(0, 16'd1, "wrap_first");
        req = 8'h80;
        do_transfer(7, 16'd8, "wrap_second");
        req = 8'h00;
    endtask

    task automatic test_stall();
        bit ok;
        tb_i[1] = 16'h1234;
        out_ready = 1'b0;
        req = 8'h02;
        wait_valid("stall", ok);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            tests_run++;
            if (out !== 16'h1234 || {s2, s1, s0} !== 3'd1 || grant !== 8'h02 ||
                out_valid !== 1'b1 || ack !== 8'h00) begin
                tests_failed++;
                $display("FAIL stall_hold: actual out=%h sel=%0d grant=%h valid=%b ack=%h required 1234/1/02/1/00",
                         out, {s2, s1, s0}, grant, out_valid, ack);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ack !== 8'h02 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_release: actual ack=%h valid=%b required 02/0", ack, out_valid);
        end
        $display("[TB] stall: requester 1 word %h ack %h", out, ack);
        req = 8'h00;
    endtask

    task automatic test_capture();
        bit ok;
        tb_i[2] = 16'd22;
        out_ready = 1'b0;
        req = 8'h04;
        wait_valid("capture", ok);
        tb_i[2] = 16'd99;
        req = 8'h00;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (out !== 16'd22 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL capture_hold: actual out=%0d valid=%b required 22/1", out, out_valid);
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ack !== 8'h04 || out !== 16'd22) begin
            tests_failed++;
            $display("FAIL capture_ack: actual ack=%h out=%0d required 04/22", ack, out);
        end
        $display("[TB] capture: requester 2 word %0d ack %h", out, ack);
        tb_i[2] = 16'd22;
    endtask

    task automatic test_async_reset();
        bit ok;
        out_ready = 1'b0;
        req = 8'h08;
        wait_valid("async_reset", ok);
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || grant !== 8'h00 || ack !== 8'h00 || out !== 16'd0 ||
            {s2, s1, s0} !== 3'd0) begin
            tests_failed++;
            $display("FAIL async_reset: actual valid=%b grant=%h ack=%h out=%0d sel=%0d required all 0",
                     out_valid, grant, ack, out, {s2, s1, s0});
        end
        $display("[TB] async_reset: valid=%b grant=%h out=%0d", out_valid, grant, out);
        @(negedge clk);
        reset = 1'b0;
        req = 8'h00;
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || ack !== 8'h00) begin
            tests_failed++;
            $display("FAIL post_reset_idle: actual valid=%b ack=%h required 0/00", out_valid, ack);
        end
        req = 8'h04;
        do_transfer(2, 16'd22, "post_reset");
        req = 8'h00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_stall();
        test_capture();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
